uart_rx_gen: RTL and testbench
==============================

UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 651, sys_clk cycles per oversample tick (16 ticks per bit; 651 -> 9600 baud at 100 MHz).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked, legal 1..2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries, power of two, 2..16.
REQ-006 SHALL have port sys_clk  input  1  sole clock, all logic rising-edge.
REQ-007 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rx_port  input  1  serial line, idle high, asynchronous to sys_clk.
REQ-009 SHALL have port rx_ack  input  1  pop request for FIFO head.
REQ-010 SHALL have port rx_data  output  DATA_BITS  FIFO head data, LSB = first received bit.
REQ-011 SHALL have port rx_ready  output  1  FIFO non-empty.
REQ-012 SHALL have port rx_frame_err  output  1  FIFO head received with bad stop bit.
REQ-013 SHALL have port rx_parity_err  output  1  FIFO head received with bad parity (always 0 when PARITY=0).
REQ-014 SHALL have port rx_overrun  output  1  sticky: at least one frame dropped due to full FIFO.
REQ-015 SHALL have port rx_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL pass rx_port through a two-flop synchroniser; all sampling uses the synchronised value.
REQ-017 SHALL generate an oversample tick every CLK_DIV cycles from a counter restarted on start-edge detection.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 IDLE: on synchronised line low, SHALL restart the tick counter and the 4-bit sample counter and go to START.
REQ-020 Bit value SHALL be the majority of samples 7, 8, 9 of the 16 ticks in each bit period.
REQ-021 START: if the start-bit majority is high, SHALL return to IDLE (glitch reject) with no FIFO write; else go to DATA.
REQ-022 DATA: SHALL shift in DATA_BITS bits LSB first, then go to PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: SHALL flag parity error when the XOR of data bits and the parity bit is 0 for odd, or 1 for even.
REQ-024 STOP: SHALL check STOP_BITS stop bits; any stop sample low sets frame error; the second stop bit SHALL NOT be checked once the first is low.
REQ-025 SHALL write {data, frame_err, parity_err} to the FIFO one cycle after the final stop-bit decision; rx_ready SHALL rise the following cycle when the FIFO was empty.
REQ-026 After a frame error, SHALL enter WAIT_HIGH and stay there until the synchronised line is high (break handling); else return to IDLE directly.
REQ-027 FIFO SHALL be first-word-fall-through: rx_data and the error flags reflect the head whenever rx_ready=1; contents are don't-care when rx_ready=0.
REQ-028 rx_ack with rx_ready=1 SHALL pop one entry; rx_ack with rx_ready=0 SHALL be ignored.
REQ-029 Write with FIFO full and no simultaneous pop SHALL drop the frame and set rx_overrun; write and pop in the same cycle when full SHALL both succeed, with rx_level unchanged.
REQ-030 rx_overrun SHALL clear on the cycle after any accepted pop, unless an overrun is set in that same cycle (set wins).
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; rx_level SHALL reach exactly FIFO_DEPTH when full.

Reset
REQ-032 sys_rst high SHALL immediately force state IDLE, counters 0, FIFO empty, rx_ready=0, rx_data=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0, rx_level=0, and synchroniser flops to 1.
REQ-033 Reset mid-frame SHALL discard the partial frame; after release, the receiver SHALL wait for a fresh falling edge.

Verification (CLK_DIV=4, i.e. 64 clocks/bit, DATA_BITS=8, PARITY=2, STOP_BITS=1, FIFO_DEPTH=4)
REQ-034 Send 0xA5 with correct even parity -> rx_ready=1, rx_data=0xA5, both error flags 0, rx_level=1; rx_ack -> rx_ready=0.
REQ-035 Send 0x3C with wrong parity bit -> rx_data=0x3C, rx_parity_err=1; send 0x00 with stop low, line held low 20 bit-times -> rx_frame_err=1, one entry only, next frame accepted after line returns high.
REQ-036 30-clock low glitch on idle line -> no FIFO write, state back to IDLE.
REQ-037 Send 5 frames 0x01..0x05 with no ack -> rx_level=4, rx_overrun=1, pops return 0x01..0x04; rx_overrun clears after the first pop.
REQ-038 Assert sys_rst asynchronously in the middle of DATA -> all outputs at reset values without a clock edge; next complete frame 0x5A is received correctly.
REQ-039 Single-sample flip at sample 8 of each data bit of 0xC3 -> majority vote yields 0xC3 with no errors.

Source files
------------

// File: rtl/uart_rx_gen_if.sv
// Receive-side FIFO handshake between uart_rx_gen (master) and its consumer (slave).
// The receiver presents the FIFO head; the consumer pops it with rx_ack.
interface uart_rx_gen_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]          rx_data;
    logic                          rx_ack;
    logic                          rx_ready;
    logic                          rx_frame_err;
    logic                          rx_parity_err;
    logic                          rx_overrun;
    logic [$clog2(FIFO_DEPTH):0]   rx_level;

    modport master (
        input  rx_ack,
        output rx_data, rx_ready, rx_frame_err, rx_parity_err, rx_overrun, rx_level
    );

    modport slave (
        output rx_ack,
        input  rx_data, rx_ready, rx_frame_err, rx_parity_err, rx_overrun, rx_level
    );
endinterface

// File: rtl/uart_rx_gen.sv
// 16x oversampling UART receiver with majority-vote bit decisions and a
// first-word-fall-through receive FIFO carrying per-frame error flags.
module uart_rx_gen #(
    parameter int unsigned CLK_DIV    = 651,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          rx_port,
    uart_rx_gen_if.master rx_if
);
    localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned BitW  = $clog2(DATA_BITS);
    localparam int unsigned WordW = DATA_BITS + 2;

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitHigh
    } state_e;

    state_e                state_q, state_d;
    logic                  sync1_q, sync1_d, sync2_q, sync2_d;
    logic                  vld1_q, vld1_d, vld2_q, vld2_d;
    logic                  armed_q, armed_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [3:0]            smp_q, smp_d;
    logic                  s7_q, s7_d, s8_q, s8_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic                  wr_q, wr_d;
    logic [WordW-1:0]      word_q, word_d;
    logic [WordW-1:0]      mem_q [FIFO_DEPTH];
    logic [WordW-1:0]      mem_d [FIFO_DEPTH];
    logic [AddrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AddrW:0]        count_q, count_d;
    logic                  ovr_q, ovr_d;

    logic                  rx_s, tick, decide, maj;
    logic                  empty, full, pop, push;
    logic [WordW-1:0]      head;

    assign rx_s   = sync2_q;
    assign tick   = (div_q == DivW'(CLK_DIV - 1));
    assign decide = tick && (smp_q == 4'd9);
    assign maj    = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

    // Receiver: every bit is decided at sample 9, so the stop decision lands
    // mid-bit and IDLE is already watching for the next start edge.
    always_comb begin
        state_d = state_q;
        sync1_d = rx_port;
        sync2_d = sync1_q;
        vld1_d  = 1'b1;
        vld2_d  = vld1_q;
        armed_d = armed_q;
        div_d   = tick ? '0 : div_q + DivW'(1);
        smp_d   = tick ? smp_q + 4'd1 : smp_q;
        s7_d    = (tick && smp_q == 4'd7) ? rx_s : s7_q;
        s8_d    = (tick && smp_q == 4'd8) ? rx_s : s8_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        wr_d    = 1'b0;
        word_d  = word_q;

        // Armed only once a real (post-reset) high level is seen: a fresh edge is required.
        if (vld2_q && rx_s) armed_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (armed_q && !rx_s) begin
                    div_d   = '0;
                    smp_d   = '0;
                    armed_d = 1'b0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (decide) state_d = maj ? StIdle : StData;
            end
            StData: begin
                if (decide) begin
                    shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BitW'(1);
                    if (32'(bit_q) == DATA_BITS - 1) begin
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (decide) begin
                    perr_d  = (PARITY == 1) ? ~(^shreg_q ^ maj) : (^shreg_q ^ maj);
                    state_d = StStop;
                end
            end
            StStop: begin
                if (decide) begin
                    if (!maj) begin
                        wr_d    = 1'b1;
                        word_d  = {shreg_q, 1'b1, perr_q};
                        state_d = StWaitHigh;
                    end else if (32'(stop_q) == STOP_BITS - 1) begin
                        wr_d    = 1'b1;
                        word_d  = {shreg_q, 1'b0, perr_q};
                        state_d = StIdle;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            StWaitHigh: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == (AddrW + 1)'(FIFO_DEPTH));
    assign pop   = rx_if.rx_ack && !empty;
    assign push  = wr_q && (!full || pop);

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = word_q;
        wptr_d  = push ? wptr_q + AddrW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AddrW'(1) : rptr_q;
        count_d = count_q + (AddrW + 1)'(push) - (AddrW + 1)'(pop);
        // A dropped write in the same cycle as a pop is impossible, so set simply wins.
        if (wr_q && full && !pop) ovr_d = 1'b1;
        else if (pop)             ovr_d = 1'b0;
        else                      ovr_d = ovr_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            armed_q <= 1'b0;
            div_q   <= '0;
            smp_q   <= '0;
            s7_q    <= 1'b1;
            s8_q    <= 1'b1;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            wr_q    <= 1'b0;
            word_q  <= '0;
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            vld1_q  <= vld1_d;
            vld2_q  <= vld2_d;
            armed_q <= armed_d;
            div_q   <= div_d;
            smp_q   <= smp_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            wr_q    <= wr_d;
            word_q  <= word_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    assign head                = mem_q[rptr_q];
    assign rx_if.rx_ready      = !empty;
    assign rx_if.rx_data       = empty ? '0 : head[WordW-1:2];
    assign rx_if.rx_frame_err  = !empty && head[1];
    assign rx_if.rx_parity_err = !empty && head[0];
    assign rx_if.rx_overrun    = ovr_q;
    assign rx_if.rx_level      = count_q;
endmodule

// File: tb/tb_uart_rx_gen.sv
// Directed bench for uart_rx_gen (CLK_DIV=4, 8E1, 4-entry FIFO): a queue model of
// the FIFO is checked every cycle, plus literal expectations after each scenario.
module tb_uart_rx_gen;
    localparam int unsigned BitClks = 64;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic rx_port = 1'b1;

    uart_rx_gen_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) rx_if ();

    uart_rx_gen #(
        .CLK_DIV    (4),
        .DATA_BITS  (8),
        .PARITY     (2),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx_port (rx_port),
        .rx_if   (rx_if)
    );

    always #5 sys_clk = ~sys_clk;

    int        checks   = 0;
    int        failures = 0;
    bit        chk_en   = 1'b0;
    logic [9:0] mq[$];  // {data, frame_err, parity_err}
    bit        ovr_m    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Even parity: an odd count of ones over data+parity is an error.
    task automatic model_write(input logic [7:0] d, input logic pbit, input logic stop);
        logic [9:0] w;
        w = {d, ~stop, ^{d, pbit}};
        if (mq.size() < 4) mq.push_back(w);
        else ovr_m = 1'b1;
    endtask

    initial forever begin
        @(posedge sys_clk);
        #1;
        if (chk_en) begin
            chk("m_ready", 32'(rx_if.rx_ready), 32'(mq.size() != 0));
            chk("m_level", 32'(rx_if.rx_level), mq.size());
            chk("m_overrun", 32'(rx_if.rx_overrun), 32'(ovr_m));
            if (mq.size() != 0) begin
                chk("m_data", 32'(rx_if.rx_data), 32'(mq[0][9:2]));
                chk("m_ferr", 32'(rx_if.rx_frame_err), 32'(mq[0][1]));
                chk("m_perr", 32'(rx_if.rx_parity_err), 32'(mq[0][0]));
            end
        end
    end

    task automatic idle_bits(input int n);
        repeat (n * BitClks) @(negedge sys_clk);
    endtask

    // One bit period; with flip, only the window around sample 8 is inverted.
    task automatic tx_bit(input logic v, input bit flip);
        @(negedge sys_clk);
        rx_port = v;
        if (flip) begin
            repeat (35) @(negedge sys_clk);
            rx_port = ~v;
            repeat (3) @(negedge sys_clk);
            rx_port = v;
            repeat (25) @(negedge sys_clk);
        end else begin
            repeat (BitClks - 1) @(negedge sys_clk);
        end
    endtask

    task automatic tx_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input bit flip);
        tx_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tx_bit(d[i], flip);
        tx_bit(pbit, 1'b0);
        chk_en = 1'b0;
        tx_bit(stop, 1'b0);
        model_write(d, pbit, stop);
        chk_en = 1'b1;
    endtask

    task automatic pop_one();
        @(negedge sys_clk);
        rx_if.rx_ack = 1'b1;
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            ovr_m = 1'b0;
        end
        @(negedge sys_clk);
        rx_if.rx_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(rx_if.rx_ready), 0);
        chk({tag, "_level"}, 32'(rx_if.rx_level), 0);
        chk({tag, "_data"}, 32'(rx_if.rx_data), 0);
        chk({tag, "_ferr"}, 32'(rx_if.rx_frame_err), 0);
        chk({tag, "_perr"}, 32'(rx_if.rx_parity_err), 0);
        chk({tag, "_ovr"}, 32'(rx_if.rx_overrun), 0);
    endtask

    initial begin
        logic [7:0] d;
        rx_if.rx_ack = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_reset_vals("rst0");
        sys_rst = 1'b0;
        idle_bits(2);
        chk_en = 1'b1;

        // 0xA5 has four ones: even parity bit 0.
        tx_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        chk("a5_ready", 32'(rx_if.rx_ready), 1);
        chk("a5_data", 32'(rx_if.rx_data), 32'hA5);
        chk("a5_ferr", 32'(rx_if.rx_frame_err), 0);
        chk("a5_perr", 32'(rx_if.rx_parity_err), 0);
        chk("a5_level", 32'(rx_if.rx_level), 1);
        pop_one();
        chk("a5_popped", 32'(rx_if.rx_ready), 0);

        // 0x3C has four ones; parity bit 1 is wrong.
        tx_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        chk("3c_data", 32'(rx_if.rx_data), 32'h3C);
        chk("3c_perr", 32'(rx_if.rx_parity_err), 1);
        chk("3c_ferr", 32'(rx_if.rx_frame_err), 0);
        pop_one();

        // Break: stop low, line held low for 20 bit times.
        tx_frame(8'h00, 1'b0, 1'b0, 1'b0);
        idle_bits(20);
        chk("brk_ferr", 32'(rx_if.rx_frame_err), 1);
        chk("brk_data", 32'(rx_if.rx_data), 0);
        rx_port = 1'b1;
        idle_bits(2);
        chk("brk_level", 32'(rx_if.rx_level), 1);
        pop_one();
        tx_frame(8'h11, 1'b0, 1'b1, 1'b0);
        chk("post_brk_data", 32'(rx_if.rx_data), 32'h11);
        chk("post_brk_ferr", 32'(rx_if.rx_frame_err), 0);
        pop_one();

        // 30-clock glitch must be rejected.
        @(negedge sys_clk);
        rx_port = 1'b0;
        repeat (30) @(negedge sys_clk);
        rx_port = 1'b1;
        idle_bits(2);
        chk("glitch_level", 32'(rx_if.rx_level), 0);
        tx_frame(8'h77, 1'b0, 1'b1, 1'b0);
        chk("post_glitch_data", 32'(rx_if.rx_data), 32'h77);
        chk("post_glitch_level", 32'(rx_if.rx_level), 1);
        pop_one();

        // Five frames without ack: the fifth is dropped.
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            tx_frame(d, ^d, 1'b1, 1'b0);
        end
        chk("ovr_level", 32'(rx_if.rx_level), 4);
        chk("ovr_flag", 32'(rx_if.rx_overrun), 1);
        chk("ovr_head1", 32'(rx_if.rx_data), 32'h01);
        pop_one();
        chk("ovr_cleared", 32'(rx_if.rx_overrun), 0);
        chk("ovr_head2", 32'(rx_if.rx_data), 32'h02);
        pop_one();
        chk("ovr_head3", 32'(rx_if.rx_data), 32'h03);
        pop_one();
        chk("ovr_head4", 32'(rx_if.rx_data), 32'h04);
        pop_one();
        chk("ovr_drained", 32'(rx_if.rx_ready), 0);

        // Leave an entry queued, then reset in the middle of a frame's data bits.
        tx_frame(8'h99, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(rx_if.rx_level), 1);
        @(negedge sys_clk);
        rx_port = 1'b0;
        repeat (3 * BitClks - 1) @(negedge sys_clk);
        chk_en = 1'b0;
        #2;
        sys_rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        mq.delete();
        ovr_m = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk_en = 1'b1;
        idle_bits(2);
        chk("rst_low_level", 32'(rx_if.rx_level), 0);
        rx_port = 1'b1;
        idle_bits(2);
        tx_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("5a_data", 32'(rx_if.rx_data), 32'h5A);
        chk("5a_level", 32'(rx_if.rx_level), 1);
        chk("5a_perr", 32'(rx_if.rx_parity_err), 0);
        pop_one();

        // Sample-8 flips in every data bit are outvoted.
        tx_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        chk("c3_data", 32'(rx_if.rx_data), 32'hC3);
        chk("c3_ferr", 32'(rx_if.rx_frame_err), 0);
        chk("c3_perr", 32'(rx_if.rx_parity_err), 0);
        chk("c3_level", 32'(rx_if.rx_level), 1);
        pop_one();
        chk("final_empty", 32'(rx_if.rx_ready), 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
